// File: rtl/pc_gen.sv
// Program counter generator for the fetch stage.
// Handles boot, sequential advance, redirects, traps and halt/resume.
module pc_gen #(
    parameter int unsigned    N         = 32,
    parameter logic [N-1:0]   RESET_VEC = 32'h0040_0000,
    parameter logic [N-1:0]   TRAP_VEC  = 32'h0040_0180,
    parameter int unsigned    INC       = 4,
    parameter int unsigned    CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [N-1:0]     redirect_target,
    input  logic             trap_req,
    input  logic             halt,
    input  logic             resume,
    output logic [N-1:0]     pc_value,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             mis_d;
    logic             aligned;
    logic             accept;

    assign aligned = (redirect_target[1:0] == 2'b00);
    assign accept  = fetch_ready && !stall;

    // State, PC, counter and error pulse registers; falling-edge clocked.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_value     <= RESET_VEC;
            fetch_count  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_value     <= pc_d;
            fetch_count  <= cnt_d;
            misalign_err <= mis_d;
        end
    end

    // Next-state and next-PC selection, trap > redirect > halt/resume > fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_value;
        cnt_d   = fetch_count;
        mis_d   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    pc_d = TRAP_VEC;
                end else if (redirect_valid) begin
                    if (aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d  = TRAP_VEC;
                        mis_d = 1'b1;
                    end
                end else if (halt) begin
                    state_d = HALTED;
                end else if (accept) begin
                    pc_d  = pc_value + N'(INC);
                    cnt_d = fetch_count + CNT_W'(1);
                end
            end
            HALTED: begin
                if (trap_req) begin
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end else if (redirect_valid) begin
                    if (aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d    = TRAP_VEC;
                        mis_d   = 1'b1;
                        state_d = RUN;
                    end
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    // Fetch request is live only while running.
    always_comb begin
        pc_valid = (state_q == RUN);
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen.
// State updates on the falling edge; outputs are checked 1 unit later.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        halt;
    logic        resume;
    logic [31:0] pc_value;
    logic        pc_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    pc_gen dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .halt            (halt),
        .resume          (resume),
        .pc_value        (pc_value),
        .pc_valid        (pc_valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        fetch_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_req        = 1'b0;
        halt            = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0000 || pc_valid !== 1'b0 ||
            misalign_err !== 1'b0 || fetch_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset: pc=%h v=%b m=%b c=%0d want 00400000 0 0 0",
                     pc_value, pc_valid, misalign_err, fetch_count);
        end
    endtask

    task automatic test_boot();
        logic [31:0] exp_pc [3] = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0004};
        logic        exp_v  [3] = '{1'b0, 1'b1, 1'b1};
        int          exp_c  [3] = '{0, 0, 1};
        fetch_ready = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (pc_valid !== exp_v[i] || pc_value !== exp_pc[i] ||
                fetch_count !== 32'(exp_c[i])) begin
                n_err++;
                $display("FAIL boot[%0d]: v=%b pc=%h c=%0d want %b %h %0d",
                         i, pc_valid, pc_value, fetch_count,
                         exp_v[i], exp_pc[i], exp_c[i]);
            end
        end
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0008 || fetch_count !== 32'd2) begin
            n_err++;
            $display("FAIL boot_adv: pc=%h c=%0d want 00400008 2",
                     pc_value, fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [4] = '{32'h0040_0008, 32'h0040_0008,
                                    32'h0040_000C, 32'h0040_000C};
        int          exp_c  [4] = '{2, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            stall       = (i < 2);
            fetch_ready = (i < 3);
            tick();
            n_vec++;
            if (pc_value !== exp_pc[i] || fetch_count !== 32'(exp_c[i]) ||
                pc_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall[%0d]: pc=%h c=%0d v=%b want %h %0d 1",
                         i, pc_value, fetch_count, pc_valid,
                         exp_pc[i], exp_c[i]);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        stall           = 1'b1;
        fetch_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0040;
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0040 || fetch_count !== 32'd3 ||
            misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL redir_ok: pc=%h c=%0d m=%b want 00400040 3 0",
                     pc_value, fetch_count, misalign_err);
        end
        redirect_target = 32'h0040_0042;
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0180 || misalign_err !== 1'b1 ||
            pc_valid !== 1'b1 || fetch_count !== 32'd3) begin
            n_err++;
            $display("FAIL redir_mis: pc=%h m=%b v=%b c=%0d want 00400180 1 1 3",
                     pc_value, misalign_err, pc_valid, fetch_count);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (misalign_err !== 1'b0 || pc_value !== 32'h0040_0180) begin
            n_err++;
            $display("FAIL mis_pulse: m=%b pc=%h want 0 00400180",
                     misalign_err, pc_value);
        end
    endtask

    task automatic test_halt();
        fetch_ready = 1'b1;
        halt        = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (pc_valid !== 1'b0 || pc_value !== 32'h0040_0180 ||
                fetch_count !== 32'd3) begin
                n_err++;
                $display("FAIL halt[%0d]: v=%b pc=%h c=%0d want 0 00400180 3",
                         i, pc_valid, pc_value, fetch_count);
            end
            if (i < 5) tick();
        end
        halt        = 1'b1;
        resume      = 1'b1;
        fetch_ready = 1'b0;
        tick();
        n_vec++;
        if (pc_valid !== 1'b1 || pc_value !== 32'h0040_0180) begin
            n_err++;
            $display("FAIL resume: v=%b pc=%h want 1 00400180",
                     pc_valid, pc_value);
        end
        resume = 1'b0;
        tick();
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0100;
        tick();
        n_vec++;
        if (pc_valid !== 1'b0 || pc_value !== 32'h0040_0100 ||
            misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL halt_redir: v=%b pc=%h m=%b want 0 00400100 0",
                     pc_valid, pc_value, misalign_err);
        end
        redirect_target = 32'h0040_0102;
        tick();
        n_vec++;
        if (pc_valid !== 1'b1 || pc_value !== 32'h0040_0180 ||
            misalign_err !== 1'b1) begin
            n_err++;
            $display("FAIL halt_mis: v=%b pc=%h m=%b want 1 00400180 1",
                     pc_valid, pc_value, misalign_err);
        end
        redirect_valid = 1'b0;
        halt           = 1'b1;
        tick();
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0200;
        tick();
        redirect_valid = 1'b0;
        trap_req       = 1'b1;
        tick();
        trap_req = 1'b0;
        n_vec++;
        if (pc_valid !== 1'b1 || pc_value !== 32'h0040_0180) begin
            n_err++;
            $display("FAIL halt_trap: v=%b pc=%h want 1 00400180",
                     pc_valid, pc_value);
        end
    endtask

    task automatic test_trap();
        idle_inputs();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0200;
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0200) begin
            n_err++;
            $display("FAIL trap_setup: pc=%h want 00400200", pc_value);
        end
        trap_req        = 1'b1;
        redirect_target = 32'h0040_0042;
        tick();
        n_vec++;
        if (pc_value !== 32'h0040_0180 || misalign_err !== 1'b0 ||
            pc_valid !== 1'b1 || fetch_count !== 32'd3) begin
            n_err++;
            $display("FAIL trap_prio: pc=%h m=%b v=%b c=%0d want 00400180 0 1 3",
                     pc_value, misalign_err, pc_valid, fetch_count);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        tick();
        fetch_ready = 1'b0;
        n_vec++;
        if (pc_value !== 32'h0000_0000 || fetch_count !== 32'd4 ||
            misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: pc=%h c=%0d m=%b want 00000000 4 0",
                     pc_value, fetch_count, misalign_err);
        end
    endtask

    task automatic test_async_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0042;
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (pc_value !== 32'h0040_0000 || fetch_count !== 32'd0 ||
            pc_valid !== 1'b0 || misalign_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: pc=%h c=%0d v=%b m=%b want 00400000 0 0 0",
                     pc_value, fetch_count, pc_valid, misalign_err);
        end
        tick();
        idle_inputs();
        fetch_ready = 1'b1;
        reset       = 1'b1;
        tick();
        n_vec++;
        if (pc_valid !== 1'b1 || pc_value !== 32'h0040_0000 ||
            fetch_count !== 32'd0) begin
            n_err++;
            $display("FAIL reboot: v=%b pc=%h c=%0d want 1 00400000 0",
                     pc_valid, pc_value, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_halt();
        test_trap();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter N, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0040_0000, PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0040_0180, PC value loaded on trap or misaligned redirect.
REQ-004 Parameter INC, default 4, sequential PC increment.
REQ-005 Parameter CNT_W, default 32, fetch counter width.
REQ-006 clk  input  1  clock; all state updates on the falling edge.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 stall  input  1  hazard stall; 1 blocks sequential advance.
REQ-009 fetch_ready  input  1  instruction memory accepts pc_value this cycle.
REQ-010 redirect_valid  input  1  branch/jump taken.
REQ-011 redirect_target  input  N  branch/jump destination.
REQ-012 trap_req  input  1  exception/interrupt request.
REQ-013 halt  input  1  request to stop fetching.
REQ-014 resume  input  1  request to leave HALTED.
REQ-015 pc_value  output  N  current fetch address (registered).
REQ-016 pc_valid  output  1  pc_value is a live fetch request.
REQ-017 misalign_err  output  1  one-cycle pulse: redirect target not 4-byte aligned.
REQ-018 fetch_count  output  CNT_W  number of accepted fetches.

Function
REQ-019 FSM states: BOOT, RUN, HALTED; state, pc_value, misalign_err, fetch_count are registers.
REQ-020 pc_valid SHALL be 1 exactly when state is RUN (combinational decode of state).
REQ-021 Accepted fetch: state RUN and fetch_ready=1 and stall=0.
REQ-022 BOOT: next edge -> RUN unconditionally, pc_value holds RESET_VEC, all other inputs ignored.
REQ-023 RUN, priority per edge, highest first: trap_req; redirect_valid; halt; accepted fetch; hold.
REQ-024 trap_req=1 (RUN or HALTED): pc_value <= TRAP_VEC, state <= RUN, no count increment.
REQ-025 redirect_valid=1, redirect_target[1:0]==0: pc_value <= redirect_target, stay RUN, no count increment (current fetch squashed), stall ignored.
REQ-026 redirect_valid=1, redirect_target[1:0]!=0: pc_value <= TRAP_VEC, misalign_err <= 1 for one cycle, state <= RUN.
REQ-027 halt=1 (no trap/redirect): state <= HALTED, pc_value holds, no count increment even if fetch_ready=1.
REQ-028 Accepted fetch: pc_value <= pc_value + INC modulo 2^N; fetch_count <= fetch_count + 1 modulo 2^CNT_W.
REQ-029 Otherwise (stall=1 or fetch_ready=0): pc_value and fetch_count hold.
REQ-030 HALTED: priority trap_req; redirect_valid (aligned: load target, stay HALTED; misaligned: TRAP_VEC, pulse, -> RUN); resume -> RUN; else hold.
REQ-031 halt and resume both 1 in HALTED: resume wins; in RUN halt wins.
REQ-032 misalign_err SHALL be 0 on every edge not covered by REQ-026/REQ-030 misaligned case.
REQ-033 pc_value + INC overflow at 2^N-INC SHALL wrap to 0 without error indication.

Reset
REQ-034 reset=0 SHALL immediately, independent of clk: pc_value=RESET_VEC, state=BOOT, pc_valid=0, misalign_err=0, fetch_count=0.
REQ-035 reset asserted mid-operation (any state, any pending redirect/trap) SHALL abort it with the REQ-034 values.
REQ-036 First edge after reset release: BOOT -> RUN; first fetch of RESET_VEC accepted no earlier than the second edge.

Verification
REQ-037 Release reset, fetch_ready=1, stall=0, 3 edges -> pc_valid 0,1,1; pc_value 0x400000, 0x400000, 0x400004; fetch_count 0,0,1.
REQ-038 RUN at 0x400008, stall=1 with fetch_ready=1 for 2 edges, then stall=0 -> pc holds 0x400008 twice then 0x40000C; count increments once.
REQ-039 RUN, redirect_valid=1 target 0x400040 with stall=1 -> pc 0x400040, count unchanged; target 0x400042 -> pc 0x400180, misalign_err=1 for exactly one cycle.
REQ-040 RUN, halt=1 with fetch_ready=1 -> HALTED, pc_valid=0, pc/count frozen 5 cycles; resume=1 -> pc_valid=1 next cycle, same pc.
REQ-041 trap_req=1 and redirect_valid=1 same edge in RUN -> pc 0x400180; trap_req in HALTED -> RUN at 0x400180.
REQ-042 N=32, pc 0xFFFF_FFFC accepted fetch -> pc 0x0000_0000; reset pulsed asynchronously between clock edges -> pc 0x400000, count 0, pc_valid 0 without a clock edge.
